// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port: first fills every
// register with INIT_VAL, then alternates priority between ALU (A) and load (B) writers.
module regfile_wb_arbiter #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 2,
    parameter int                NREGS    = 4,
    parameter logic [DATA_W-1:0] INIT_VAL = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              init_done,
    output logic              last_grant
);

    localparam logic [0:0]        ST_INIT  = 1'b0;
    localparam logic [0:0]        ST_RUN   = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              init_done_q, init_done_d;
    logic              last_grant_q, last_grant_d;
    logic              a_ready_s, b_ready_s;

    // Grant decision: depends only on valids, last_grant and state, never on addr/data.
    always_comb begin
        a_ready_s = 1'b0;
        b_ready_s = 1'b0;
        if (state_q == ST_RUN) begin
            a_ready_s = a_valid & (~b_valid | last_grant_q);
            b_ready_s = b_valid & (~a_valid | ~last_grant_q);
        end else begin
            a_ready_s = 1'b0;
            b_ready_s = 1'b0;
        end
    end

    // Next-state and next-output computation for INIT fill and RUN arbitration.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        init_done_d  = init_done_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_INIT: begin
                wr_en_d   = 1'b1;
                wr_addr_d = idx_q;
                wr_data_d = INIT_VAL;
                idx_d     = idx_q + ADDR_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end else begin
                    state_d     = ST_INIT;
                end
            end
            ST_RUN: begin
                if (a_ready_s) begin
                    wr_en_d      = 1'b1;
                    wr_addr_d    = a_addr;
                    wr_data_d    = a_data;
                    last_grant_d = 1'b0;
                end else if (b_ready_s) begin
                    wr_en_d      = 1'b1;
                    wr_addr_d    = b_addr;
                    wr_data_d    = b_data;
                    last_grant_d = 1'b1;
                end else begin
                    wr_en_d      = 1'b0;
                end
            end
            default: begin
                state_d     = ST_INIT;
                idx_d       = '0;
                init_done_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; last_grant resets to B so A has first priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_INIT;
            idx_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            init_done_q  <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            init_done_q  <= init_done_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign a_ready    = a_ready_s;
    assign b_ready    = b_ready_s;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign init_done  = init_done_q;
    assign last_grant = last_grant_q;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between two writeback requesters: port A (ALU result) and port B (memory load). After reset it runs an initialisation sequence that writes a fixed value into every register, so register contents never depend on file loading. It sits between the execute/memory stages and the register file's `RegWrite`/`Wr`/`WriteData` inputs. Outputs are registered, and at most one write is issued per cycle.

## Interface

Parameters:
- `DATA_W`, default 16: register and write-data width.
- `ADDR_W`, default 2: register address width.
- `NREGS`, default 4: number of registers initialised. Must be ≤ 2^ADDR_W.
- `INIT_VAL`, default 16'h0000: value written to every register during initialisation.

Ports:
- `clk` (in, 1): clock. All state updates on the rising edge.
- `reset` (in, 1): reset, asynchronous, active-high.
- `a_valid` (in, 1): requester A has a write pending.
- `a_addr` (in, ADDR_W): requester A destination register.
- `a_data` (in, DATA_W): requester A write data.
- `a_ready` (out, 1): A's request is accepted this cycle. Combinational.
- `b_valid`, `b_addr`, `b_data`, `b_ready`: same as A, for requester B.
- `wr_en` (out, 1): registered. Drives `RegWrite`.
- `wr_addr` (out, ADDR_W): registered. Drives `Wr`.
- `wr_data` (out, DATA_W): registered. Drives `WriteData`.
- `init_done` (out, 1): registered. High once initialisation has completed.
- `last_grant` (out, 1): registered. 0 means A was granted last, 1 means B.

## Operation

State machine has two states, INIT and RUN.

Reset (asynchronous assert):
- State goes to INIT, with init index = 0.
- Outputs: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `init_done`=0, `last_grant`=1, so A has priority first.

INIT:
- `a_ready` and `b_ready` are held at 0.
- On each edge: `wr_en`←1, `wr_addr`←idx, `wr_data`←INIT_VAL, then idx increments.
- On the edge that issues idx = NREGS-1: state←RUN and `init_done`←1 on the same edge.

RUN, with priority p = !`last_grant`:
- `a_ready` = `a_valid` & (!`b_valid` | `last_grant`).
- `b_ready` = `b_valid` & (!`a_valid` | !`last_grant`).
- Never both ready in the same cycle.

Handshake completes when `x_valid` & `x_ready` at an edge. On that edge:
- `wr_en`←1, `wr_addr`←`x_addr`, `wr_data`←`x_data`.
- `last_grant`←(x==B).

With no handshake: `wr_en`←0, while `wr_addr`, `wr_data` and `last_grant` hold.

A requester holds valid, addr and data stable until accepted. Requests are never dropped and never reordered within one port.

Boundary behaviour:
- Both valid with the same `addr`: arbitrated normally. The loser is written one or more cycles later, so the later writer's value persists.
- Single requester valid: granted every cycle, back-to-back, at full throughput. `last_grant` still updates.
- Reset during INIT or RUN: immediate return to the reset state. A pending accepted write is lost, and a new INIT sequence follows.
- Addresses ≥ NREGS in RUN are passed through unchanged.

## Timing

- Reset deassert to the first init write (`wr_en`=1, addr 0): the first rising edge after deassert.
- INIT lasts exactly NREGS cycles. The first RUN handshake can occur in the cycle after the edge that sets `init_done`.
- Handshake latency: a request accepted at edge t appears on `wr_*` during cycle t→t+1. The register file captures it at edge t+1.
- The ready path is combinational from valid and `last_grant` only. It has no dependence on addr or data.
- Throughput: 1 write per cycle.
- Alternation under continuous contention: A, B, A, B, …

## Test plan

- Reset, then release: `wr_en`=1 for exactly 4 cycles with addr 0,1,2,3 and data 16'h0000. `init_done` rises with the addr-3 write. Readys stay 0 throughout.
- After init, A only, holding valid for 3 cycles with addr 2 and data 16'h1234 → 56 → 9A: three consecutive writes to addr 2 with those values. `b_ready`=0 throughout.
- Both valid continuously, A=(1,16'hAAAA), B=(3,16'hBBBB), for 4 cycles: writes alternate A,B,A,B, starting with A. `last_grant` toggles 0,1,0,1.
- Both valid to addr 0, A=16'h1111, B=16'h2222, A priority: addr 0 is written 1111 then 2222. The final register value is 16'h2222.
- Reset asserted mid-RUN while B is held valid: `wr_en` drops to 0 asynchronously. After release, the full 4-cycle INIT repeats before `b_ready` can assert.
- Idle cycle inserted between single requests: `wr_en` is 0 in the idle cycle, and `wr_addr`/`wr_data` hold the previous values.
